// File: rtl/outport_arbiter.sv
// Wormhole round-robin arbiter and credit-based flow controller for one router
// output port: picks an owner, holds it until the tail flit, strobes captures.
module outport_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int SEL_W   = 3,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic [NUM_REQ-1:0] req_din,
    input  logic [NUM_REQ-1:0] tail_din,
    input  logic               credit_return_din,
    output logic [NUM_REQ-1:0] grant_dout,
    output logic [SEL_W-1:0]   sel_dout,
    output logic               toggle_dout,
    output logic [CNT_W-1:0]   credit_cnt_dout,
    output logic               credit_err_dout,
    output logic               dbg_state_dout,
    output logic [SEL_W-1:0]   dbg_ptr_dout
);

    // Handshake: a flit moves only in a cycle where toggle_dout is high, which
    // requires the owner's req_din (valid) and at least one downstream credit (ready).

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_CREDITS = CNT_W'(CREDITS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               w_found;
    logic [SEL_W-1:0]   w_pick;
    logic               w_toggle;
    logic               w_tail_done;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[SEL_W-1:0];
    endfunction

    // Cyclic search starting at the priority pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_din[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_ptr, i);
            end
        end
    end

    // Gated by rsta so a reset mid-packet never captures a flit.
    assign w_toggle    = (r_state == XFER) && req_din[r_sel] && (r_cnt != '0) && !rsta;
    assign w_tail_done = w_toggle && tail_din[r_sel];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = XFER;
                    w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_sel_nxt   = w_pick;
                end
            end
            XFER: begin
                if (w_tail_done) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = wrap_add(r_sel, 1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A return arriving with the counter already full is dropped and flagged.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_cnt <= LP_CREDITS;
            r_err <= 1'b0;
        end else begin
            case ({w_toggle, credit_return_din})
                2'b10: r_cnt <= r_cnt - CNT_W'(1);
                2'b01: begin
                    if (r_cnt == LP_CREDITS) r_err <= 1'b1;
                    else                     r_cnt <= r_cnt + CNT_W'(1);
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign grant_dout      = r_grant;
    assign sel_dout        = r_sel;
    assign toggle_dout     = w_toggle;
    assign credit_cnt_dout = r_cnt;
    assign credit_err_dout = r_err;
    assign dbg_state_dout  = (r_state == XFER);
    assign dbg_ptr_dout    = r_ptr;

endmodule
